// File: rtl/router_port_arbiter_if.sv
// Handshake bundle between one router output port, its competing input streams
// and the arbiter that schedules them.
interface router_port_arbiter_if #(
  parameter int n_stream     = 5,
  parameter int stream_width = 132
);
  logic [n_stream-1:0]              req;
  logic [n_stream-1:0]              in_valid;
  logic [n_stream-1:0]              in_last;
  logic [n_stream*stream_width-1:0] in_data;
  logic [n_stream-1:0]              in_ready;
  logic                             out_valid;
  logic                             out_last;
  logic [stream_width-1:0]          out_data;
  logic                             out_ready;
  logic [n_stream-1:0]              grant;
  logic                             busy;
  logic                             tmo_err;

  modport master (
    output req, in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, grant, busy, tmo_err
  );

  modport slave (
    input  req, in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, grant, busy, tmo_err
  );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin output-port scheduler: holds a grant for a whole packet, drives the
// one-hot accessor select and frees the port if the granted input stalls.
module router_port_arbiter #(
  parameter int n_stream     = 5,
  parameter int stream_width = 132,
  parameter int tmo_width    = 8
) (
  input logic              clk,
  input logic              rst,
  router_port_arbiter_if.slave io_bus
);
  localparam int IW = (n_stream > 1) ? $clog2(n_stream) : 1;
  localparam logic [tmo_width-1:0] TMO_MAX   = '1;
  localparam logic [IW-1:0]        LAST_IDX  = IW'(n_stream - 1);
  localparam logic [n_stream-1:0]  GRANT_LSB = n_stream'(1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                r_state;
  logic [n_stream-1:0]   r_grant;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_gidx;
  logic [tmo_width-1:0]  r_tmo_cnt;
  logic                  r_tmo_err;

  logic [n_stream-1:0]     w_cand;
  logic                    w_found;
  logic [IW-1:0]           w_pick;
  logic                    w_gvalid;
  logic                    w_glast;
  logic                    w_xfer;
  logic [stream_width-1:0] w_gdata;
  logic [IW-1:0]           w_next_ptr;

  assign w_cand = io_bus.req & io_bus.in_valid;

  // First candidate at or after the rotating pointer, wrapping past the top input.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < n_stream; k++) begin
      int unsigned t;
      t = 32'(r_ptr) + 32'(k);
      if (t >= 32'(n_stream)) t = t - 32'(n_stream);
      if (!w_found && w_cand[IW'(t)]) begin
        w_found = 1'b1;
        w_pick  = IW'(t);
      end
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < n_stream; i++) begin
      if (r_grant[i]) w_gdata = w_gdata | io_bus.in_data[i*stream_width +: stream_width];
    end
  end

  // The grant is one-hot or zero, so masking reduces to the granted input's bits.
  assign w_gvalid   = |(r_grant & io_bus.in_valid);
  assign w_glast    = |(r_grant & io_bus.in_last);
  assign w_xfer     = w_gvalid & io_bus.out_ready;
  assign w_next_ptr = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

  assign io_bus.out_valid = w_gvalid;
  assign io_bus.out_last  = w_glast;
  assign io_bus.out_data  = w_gdata;
  assign io_bus.in_ready  = r_grant & {n_stream{io_bus.out_ready}};
  assign io_bus.grant     = r_grant;
  assign io_bus.busy      = (r_state == LOCK);
  assign io_bus.tmo_err   = r_tmo_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (w_found) begin
            r_state <= LOCK;
            r_gidx  <= w_pick;
            r_grant <= GRANT_LSB << w_pick;
          end
        end
        LOCK: begin
          if (w_xfer && w_glast) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= w_next_ptr;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TMO_MAX) begin
            // Stalled owner: abort the packet and hand priority to the next input.
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= w_next_ptr;
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b1;
          end else if (w_gvalid) begin
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

endmodule
